// File: rtl/alu_pkg.sv
// Opcode constants and FSM state encoding shared by the ALU-sharing arbiter and its users.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the one not served last.
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_valid
);

  // Grant decode from the pending-request pair
  always_comb begin
    grant       = 1'b0;
    grant_valid = 1'b0;
    case (req_valid)
      2'b01: begin
        grant       = 1'b0;
        grant_valid = 1'b1;
      end
      2'b10: begin
        grant       = 1'b1;
        grant_valid = 1'b1;
      end
      2'b11: begin
        grant       = ~last_grant;
        grant_valid = 1'b1;
      end
      default: begin
        grant       = 1'b0;
        grant_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters: accept one operation, hold the
// ALU operands in registers, sample the result after ALU_LAT cycles and return it tagged.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int W       = 32,
  parameter int OPW     = 3,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2*OPW-1:0] req_op,
  input  logic [2*W-1:0]   req_a,
  input  logic [2*W-1:0]   req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [W-1:0]     resp_data,
  output logic [OPW-1:0]   alu_op,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  input  logic [W-1:0]     alu_s,
  output logic             busy
);

  // Counter is reloaded only in IDLE, so it never needs to wrap.
  localparam int CW = $clog2(ALU_LAT + 1);

  state_e         state_r;
  state_e         state_next_s;
  logic [OPW-1:0] op_r;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic           tag_r;
  logic [CW-1:0]  cnt_r;
  logic           last_grant_r;
  logic           resp_valid_r;
  logic           resp_id_r;
  logic [W-1:0]   resp_data_r;

  logic           grant_s;
  logic           grant_valid_s;
  logic           accept_s;
  logic [1:0]     req_ready_s;
  logic [OPW-1:0] sel_op_s;
  logic [W-1:0]   sel_a_s;
  logic [W-1:0]   sel_b_s;

  rr_arb2 u_rr_arb2 (
    .req_valid   (req_valid),
    .last_grant  (last_grant_r),
    .grant       (grant_s),
    .grant_valid (grant_valid_s)
  );

  // Next-state and requester handshake decode
  always_comb begin
    state_next_s = state_r;
    req_ready_s  = 2'b00;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_valid_s) begin
          req_ready_s  = grant_s ? 2'b10 : 2'b01;
          accept_s     = 1'b1;
          state_next_s = WAIT;
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == CW'(1)) begin
          state_next_s = RESP;
        end else begin
          state_next_s = WAIT;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Steer the granted requester's operation onto the capture path
  always_comb begin
    sel_op_s = req_op[OPW-1:0];
    sel_a_s  = req_a[W-1:0];
    sel_b_s  = req_b[W-1:0];
    if (grant_s) begin
      sel_op_s = req_op[2*OPW-1:OPW];
      sel_a_s  = req_a[2*W-1:W];
      sel_b_s  = req_b[2*W-1:W];
    end else begin
      sel_op_s = req_op[OPW-1:0];
      sel_a_s  = req_a[W-1:0];
      sel_b_s  = req_b[W-1:0];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture, latency countdown and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r         <= {OPW{1'b0}};
      a_r          <= {W{1'b0}};
      b_r          <= {W{1'b0}};
      tag_r        <= 1'b0;
      cnt_r        <= {CW{1'b0}};
      last_grant_r <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_id_r    <= 1'b0;
      resp_data_r  <= {W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r  <= sel_op_s;
            a_r   <= sel_a_s;
            b_r   <= sel_b_s;
            tag_r <= grant_s;
            cnt_r <= CW'(ALU_LAT);
          end
        end
        WAIT: begin
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            resp_data_r  <= alu_s;
            resp_id_r    <= tag_r;
            resp_valid_r <= 1'b1;
          end
        end
        RESP: begin
          // Fairness is updated only once the consumer has taken the result.
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
            last_grant_r <= resp_id_r;
          end
        end
        default: begin
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_s;
  assign resp_valid = resp_valid_r;
  assign resp_id    = resp_id_r;
  assign resp_data  = resp_data_r;
  assign alu_op     = op_r;
  assign alu_a      = a_r;
  assign alu_b      = b_r;
  assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: transaction-level reference model compared every cycle, directed
// scenarios with literal results, randomized traffic, and a second instance built with ALU_LAT=3.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [5:0]  req_op = 6'd0;
  logic [63:0] req_a = 64'd0;
  logic [63:0] req_b = 64'd0;
  logic        resp_ready = 1'b0;
  logic [1:0]  req_ready;
  logic        resp_valid;
  logic        resp_id;
  logic [31:0] resp_data;
  logic [2:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_s;
  logic        busy;

  logic [1:0]  v3_valid = 2'b00;
  logic [5:0]  v3_op = 6'd0;
  logic [63:0] v3_a = 64'd0;
  logic [63:0] v3_b = 64'd0;
  logic        v3_rready = 1'b0;
  logic [1:0]  v3_ready;
  logic        v3_rvalid;
  logic        v3_rid;
  logic [31:0] v3_rdata;
  logic [2:0]  v3_aop;
  logic [31:0] v3_aa;
  logic [31:0] v3_ab;
  logic [31:0] v3_as;
  logic        v3_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic pick(input logic [1:0] v, input logic last);
    if (v == 2'b11) return ~last;
    return v[1];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  assign alu_s = alu_ref(alu_op, alu_a, alu_b);
  assign v3_as = alu_ref(v3_aop, v3_aa, v3_ab);

  alu_share_arbiter #(.W(32), .OPW(3), .ALU_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_s(alu_s), .busy(busy)
  );

  alu_share_arbiter #(.W(32), .OPW(3), .ALU_LAT(LAT3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3_valid), .req_ready(v3_ready), .req_op(v3_op),
    .req_a(v3_a), .req_b(v3_b), .resp_valid(v3_rvalid), .resp_ready(v3_rready),
    .resp_id(v3_rid), .resp_data(v3_rdata), .alu_op(v3_aop), .alu_a(v3_aa), .alu_b(v3_ab),
    .alu_s(v3_as), .busy(v3_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level model: one record in flight, aged in cycles since acceptance.
  logic        m_inflight, m_done, m_tag, m_last, m_rid;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b, m_rdata;
  logic [1:0]  m_acc;
  int          m_age;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_inflight <= 1'b0; m_done <= 1'b0; m_tag <= 1'b0; m_last <= 1'b1; m_rid <= 1'b0;
      m_op <= 3'd0; m_a <= 32'd0; m_b <= 32'd0; m_rdata <= 32'd0; m_acc <= 2'b00; m_age <= 0;
    end else begin
      m_acc <= 2'b00;
      if (!m_inflight) begin
        if (req_valid != 2'b00) begin
          m_inflight <= 1'b1;
          m_age      <= 0;
          m_tag      <= pick(req_valid, m_last);
          m_acc      <= pick(req_valid, m_last) ? 2'b10 : 2'b01;
          m_op       <= pick(req_valid, m_last) ? req_op[5:3] : req_op[2:0];
          m_a        <= pick(req_valid, m_last) ? req_a[63:32] : req_a[31:0];
          m_b        <= pick(req_valid, m_last) ? req_b[63:32] : req_b[31:0];
        end
      end else if (!m_done) begin
        m_age <= m_age + 1;
        if (m_age + 1 == LAT) begin
          m_done  <= 1'b1;
          m_rid   <= m_tag;
          m_rdata <= alu_ref(m_op, m_a, m_b);
        end
      end else if (resp_ready) begin
        m_done     <= 1'b0;
        m_inflight <= 1'b0;
        m_last     <= m_rid;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (rst_n) begin
      check("req_ready", req_ready, (!m_inflight && req_valid != 2'b00) ?
            (pick(req_valid, m_last) ? 2'b10 : 2'b01) : 2'b00);
      check("busy", busy, m_inflight);
      check("resp_valid", resp_valid, m_done);
      check("resp_id", resp_id, m_rid);
      check("resp_data", resp_data, m_rdata);
      check("alu_op", alu_op, m_op);
      check("alu_a", alu_a, m_a);
      check("alu_b", alu_b, m_b);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 2'b00; resp_ready = 1'b0; v3_valid = 2'b00; v3_rready = 1'b0;
    @(negedge clk); #1;
    check("rst_busy", busy, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_id", resp_id, 1'b0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_alu_op", alu_op, 3'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_busy3", v3_busy, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    resp_ready = 1'b1;
    while ((m_inflight || req_valid != 2'b00) && n < 50) begin
      @(posedge clk); #2;
      req_valid = req_valid & ~m_acc;
      n++;
    end
    check("idle_timeout", (n < 50), 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nresp;
    int cnt0;
    int cnt1;
    logic [31:0] datas[8];
    logic        ids[8];
    int          acc_cyc[$];

    do_reset();

    // AND from requester 0 straight after reset
    req_valid = 2'b01; req_op[2:0] = ALU_AND;
    req_a[31:0] = 32'hF0F0F0F0; req_b[31:0] = 32'hFF00FF00; resp_ready = 1'b1;
    @(negedge clk); check("t1_ready", req_ready, 2'b01);
    @(posedge clk); #2;
    req_valid = 2'b00;
    @(negedge clk);
    check("t1_busy", busy, 1'b1);
    check("t1_ready_wait", req_ready, 2'b00);
    check("t1_no_early_resp", resp_valid, 1'b0);
    repeat (LAT) @(posedge clk);
    #1;
    check("t1_resp_valid", resp_valid, 1'b1);
    check("t1_resp_data", resp_data, 32'hF000F000);
    check("t1_resp_id", resp_id, 1'b0);
    wait_idle();

    // Both requesters continuously busy: service alternates starting with 0
    do_reset();
    cnt0 = 0; cnt1 = 0; nresp = 0;
    req_valid = 2'b11; req_op = {ALU_ADD, ALU_ADD};
    req_a = {32'd16, 32'd0}; req_b = {32'd1, 32'd1}; resp_ready = 1'b1;
    for (int c = 0; c < 80 && nresp < 6; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        ids[nresp] = resp_id; datas[nresp] = resp_data; nresp++;
      end
      @(posedge clk); #2;
      if (m_acc[0]) begin cnt0++; req_a[31:0] = cnt0; end
      if (m_acc[1]) begin cnt1++; req_a[63:32] = 32'd16 + cnt1; end
    end
    check("t2_count", nresp, 6);
    for (int j = 0; j < nresp; j++) begin
      check("t2_id", ids[j], j % 2);
      check("t2_data", datas[j], ((j % 2) ? 32'd16 : 32'd0) + (j / 2) + 1);
    end
    req_valid = 2'b00;
    wait_idle();

    // Consumer stalls for 5 cycles while requester 1 waits
    resp_ready = 1'b0;
    req_valid = 2'b01; req_op[2:0] = ALU_OR;
    req_a[31:0] = 32'h12345678; req_b[31:0] = 32'h0F0F0000;
    @(posedge clk); #2;
    req_valid = 2'b10; req_op[5:3] = ALU_SLT; req_a[63:32] = 32'hFFFFFFFF; req_b[63:32] = 32'd1;
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    check("t3_timeout", (n < 20), 1'b1);
    for (int k = 0; k < 5; k++) begin
      check("t3_hold_valid", resp_valid, 1'b1);
      check("t3_hold_id", resp_id, 1'b0);
      check("t3_hold_data", resp_data, 32'h1F3F5678);
      check("t3_hold_ready", req_ready, 2'b00);
      check("t3_hold_busy", busy, 1'b1);
      @(negedge clk);
    end
    @(posedge clk); #2;
    resp_ready = 1'b1;
    wait_idle();

    // Reset asserted while the operation is waiting on the ALU
    req_valid = 2'b01; req_op[2:0] = ALU_ADD; req_a[31:0] = 32'd3; req_b[31:0] = 32'd4;
    @(posedge clk); #1;
    check("t4_busy_before", busy, 1'b1);
    check("t4_alu_a_before", alu_a, 32'd3);
    #1;
    rst_n = 1'b0; req_valid = 2'b00;
    #1;
    check("t4_busy", busy, 1'b0);
    check("t4_resp_valid", resp_valid, 1'b0);
    check("t4_alu_op", alu_op, 3'd0);
    check("t4_alu_a", alu_a, 32'd0);
    check("t4_alu_b", alu_b, 32'd0);
    check("t4_resp_data", resp_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (LAT + 6) begin
      @(negedge clk); check("t4_no_resp", resp_valid, 1'b0);
    end

    // Lone requester 1 is served every ALU_LAT+2 cycles
    @(posedge clk); #2;
    req_valid = 2'b10; req_op[5:3] = ALU_SUB; req_a[63:32] = $urandom; req_b[63:32] = $urandom;
    resp_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req_ready == 2'b10) acc_cyc.push_back(cyc);
    end
    check("t5_accepts", (acc_cyc.size() >= 5), 1'b1);
    for (int j = 1; j < acc_cyc.size(); j++) check("t5_interval", acc_cyc[j] - acc_cyc[j-1], LAT + 2);
    @(posedge clk); #2;
    req_valid = 2'b00;
    wait_idle();

    // ALU_LAT=3 instance: SUB 5-7, operands held on the ALU until the response
    v3_valid = 2'b01; v3_op[2:0] = ALU_SUB; v3_a[31:0] = 32'd5; v3_b[31:0] = 32'd7;
    v3_rready = 1'b0;
    @(negedge clk); check("t6_ready", v3_ready, 2'b01);
    @(posedge clk); #2;
    v3_valid = 2'b00; v3_op[2:0] = ALU_AND; v3_a[31:0] = 32'd0;
    for (int k = 0; k < LAT3; k++) begin
      @(negedge clk);
      check("t6_no_early_resp", v3_rvalid, 1'b0);
      check("t6_alu_op", v3_aop, ALU_SUB);
      check("t6_alu_a", v3_aa, 32'd5);
      check("t6_alu_b", v3_ab, 32'd7);
      check("t6_busy", v3_busy, 1'b1);
    end
    @(negedge clk);
    check("t6_resp_valid", v3_rvalid, 1'b1);
    check("t6_resp_data", v3_rdata, 32'hFFFFFFFE);
    check("t6_resp_id", v3_rid, 1'b0);
    check("t6_alu_a_end", v3_aa, 32'd5);
    @(posedge clk); #2;
    v3_rready = 1'b1;
    @(posedge clk); #2;
    check("t6_idle", v3_busy, 1'b0);
    check("t6_resp_dropped", v3_rvalid, 1'b0);

    // Randomized traffic; requesters hold their operation until accepted
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #2;
      req_valid = req_valid & ~m_acc;
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_op[i*3 +: 3] = 3'($urandom_range(0, 7));
          req_a[i*32 +: 32] = $urandom;
          req_b[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? req_a[i*32 +: 32] : $urandom;
        end
      end
      resp_ready = ($urandom_range(0, 2) != 0);
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
